// File: rtl/mem_port_arbiter.sv
// Single-ported memory sequencer shared by instruction fetch (I) and load/store (D).
// One access in flight at a time; stale fetches under branch flush complete but are discarded.
module mem_port_arbiter #(
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ready,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ready,
    input  logic            flush_i,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_f,
    output logic            stall_m
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [WCW-1:0] WAIT_INIT  = WCW'(LATENCY - 1);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    logic [1:0]      r_state;
    logic            r_own_i;
    logic            r_kill;
    logic [SCW-1:0]  r_starve;
    logic [WCW-1:0]  r_wait;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic [DW-1:0]   r_wdata;
    logic [DW/8-1:0] r_be;
    logic [DW-1:0]   r_i_rdata;
    logic [DW-1:0]   r_d_rdata;

    logic w_idle;
    logic w_i_elig;
    logic w_starved;
    logic w_grant_i;
    logic w_grant_d;
    logic w_resp;
    logic w_capture;

    // A fetch is never eligible in a flush cycle; it only beats D once it has starved.
    assign w_idle    = (r_state == S_IDLE);
    assign w_i_elig  = i_req & ~flush_i;
    assign w_starved = (r_starve == STARVE_LIM);
    assign w_grant_i = w_idle & w_i_elig & (~d_req | w_starved);
    assign w_grant_d = w_idle & d_req & ~w_grant_i;
    assign w_resp    = (r_state == S_RESP);
    assign w_capture = (r_state == S_WAIT) && (r_wait == '0);

    assign mem_en    = (r_state == S_ISSUE);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

    assign i_ready   = w_resp & r_own_i & ~r_kill & ~flush_i;
    assign d_ready   = w_resp & ~r_own_i;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall_f   = i_req & ~i_ready;
    assign stall_m   = d_req & ~d_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_own_i  <= 1'b0;
            r_kill   <= 1'b0;
            r_starve <= '0;
            r_wait   <= '0;
        end else begin
            if (r_own_i && flush_i && !w_idle)
                r_kill <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_i || w_grant_d) begin
                        r_state <= S_ISSUE;
                        r_own_i <= w_grant_i;
                        r_kill  <= 1'b0;
                        if (w_grant_i)
                            r_starve <= '0;
                        else if (w_i_elig && !w_starved)
                            r_starve <= r_starve + 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_wait  <= WAIT_INIT;
                end
                S_WAIT: begin
                    if (r_wait == '0)
                        r_state <= S_RESP;
                    else
                        r_wait <= r_wait - 1'b1;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Command latch: only meaningful while mem_en is high, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_grant_i || w_grant_d) begin
            r_addr  <= w_grant_i ? i_addr : d_addr;
            r_we    <= w_grant_d & d_we;
            r_wdata <= d_wdata;
            r_be    <= w_grant_i ? '1 : d_be;
        end
    end

    // A killed fetch still completes on the bus, but its data never reaches i_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (w_capture) begin
            if (!r_own_i) begin
                r_d_rdata <= mem_rdata;
            end else if (!r_kill && !flush_i) begin
                r_i_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 runs LATENCY=1/STARVE_MAX=2, instance 1 LATENCY=3/STARVE_MAX=4.
// A schedule-based model checks every cycle; directed sequences pin literal timings and values.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_req    [2];
    logic [31:0] i_addr   [2];
    logic        d_req    [2];
    logic        d_we     [2];
    logic [31:0] d_addr   [2];
    logic [31:0] d_wdata  [2];
    logic [3:0]  d_be     [2];
    logic        flush    [2];
    logic [31:0] i_rdata  [2];
    logic [31:0] d_rdata  [2];
    logic        i_ready  [2];
    logic        d_ready  [2];
    logic        mem_en   [2];
    logic        mem_we   [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic [3:0]  mem_be   [2];
    logic [31:0] mem_rdata[2];
    logic        stall_f  [2];
    logic        stall_m  [2];

    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    mem_port_arbiter #(.LATENCY(1), .STARVE_MAX(2), .AW(32), .DW(32)) dut0 (
        .clk(clk), .rst(rst),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ready(i_ready[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_be(d_be[0]), .d_rdata(d_rdata[0]), .d_ready(d_ready[0]), .flush_i(flush[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_be(mem_be[0]), .mem_rdata(mem_rdata[0]),
        .stall_f(stall_f[0]), .stall_m(stall_m[0])
    );

    mem_port_arbiter #(.LATENCY(3), .STARVE_MAX(4), .AW(32), .DW(32)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ready(i_ready[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_be(d_be[1]), .d_rdata(d_rdata[1]), .d_ready(d_ready[1]), .flush_i(flush[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_be(mem_be[1]), .mem_rdata(mem_rdata[1]),
        .stall_f(stall_f[1]), .stall_m(stall_m[1])
    );

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int smax(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h01010101) + 32'h1357;
    endfunction

    // Memory macro: data for an access appears exactly LATENCY cycles after mem_en.
    always @(posedge clk) begin
        pipe_a    <= mem_en[0] ? memval(mem_addr[0]) : 32'hBAD0BAD0;
        pipe_b[0] <= mem_en[1] ? memval(mem_addr[1]) : 32'hBAD0BAD0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mem_rdata[0] = pipe_a;
    assign mem_rdata[1] = pipe_b[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Model: one access at a time, scheduled from its arbitration cycle t0.
    bit          m_busy  [2];
    bit          m_own_i [2];
    bit          m_kill  [2];
    bit          m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_be    [2];
    int          m_t0    [2];
    int          m_starve[2];

    task automatic model_step(input int k);
        int L;
        bit ie, e_en, e_ir, e_dr, at_resp;
        L       = lat(k);
        at_resp = m_busy[k] && (cyc == m_t0[k] + 2 + L);
        e_en    = m_busy[k] && (cyc == m_t0[k] + 1);
        e_dr    = at_resp && !m_own_i[k];
        e_ir    = at_resp && m_own_i[k] && !m_kill[k] && !flush[k];
        if (chk_en) begin
            chk($sformatf("model mem_en[%0d] c%0d", k, cyc), mem_en[k], e_en);
            chk($sformatf("model i_ready[%0d] c%0d", k, cyc), i_ready[k], e_ir);
            chk($sformatf("model d_ready[%0d] c%0d", k, cyc), d_ready[k], e_dr);
            chk($sformatf("model stall_f[%0d] c%0d", k, cyc), stall_f[k], i_req[k] & ~e_ir);
            chk($sformatf("model stall_m[%0d] c%0d", k, cyc), stall_m[k], d_req[k] & ~e_dr);
            if (e_en) begin
                chk($sformatf("model mem_addr[%0d]", k), mem_addr[k], m_addr[k]);
                chk($sformatf("model mem_we[%0d]", k), mem_we[k], m_we[k]);
                chk($sformatf("model mem_be[%0d]", k), mem_be[k], m_be[k]);
                if (m_we[k]) chk($sformatf("model mem_wdata[%0d]", k), mem_wdata[k], m_wdata[k]);
            end
            if (e_ir) chk($sformatf("model i_rdata[%0d]", k), i_rdata[k], memval(m_addr[k]));
            if (e_dr && !m_we[k]) chk($sformatf("model d_rdata[%0d]", k), d_rdata[k], memval(m_addr[k]));
        end
        if (rst) begin
            m_busy[k] = 1'b0; m_kill[k] = 1'b0; m_starve[k] = 0;
        end else if (m_busy[k]) begin
            if (m_own_i[k] && flush[k] && cyc > m_t0[k]) m_kill[k] = 1'b1;
            if (at_resp) m_busy[k] = 1'b0;
        end else begin
            ie = i_req[k] && !flush[k];
            if (ie && (!d_req[k] || m_starve[k] == smax(k))) begin
                m_own_i[k] = 1'b1; m_addr[k] = i_addr[k]; m_we[k] = 1'b0; m_be[k] = 4'hF;
                m_starve[k] = 0; m_busy[k] = 1'b1; m_t0[k] = cyc; m_kill[k] = 1'b0;
            end else if (d_req[k]) begin
                m_own_i[k] = 1'b0; m_addr[k] = d_addr[k]; m_we[k] = d_we[k];
                m_wdata[k] = d_wdata[k]; m_be[k] = d_be[k];
                if (ie && m_starve[k] < smax(k)) m_starve[k]++;
                m_busy[k] = 1'b1; m_t0[k] = cyc; m_kill[k] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_literal(input logic [31:0] a, input logic [31:0] expv);
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = a;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("load mem_en t+%0d", j), mem_en[0], j == 1);
            chk($sformatf("load d_ready t+%0d", j), d_ready[0], j == 3);
            chk($sformatf("load stall_m t+%0d", j), stall_m[0], j < 3);
            if (j == 1) chk("load mem_addr", mem_addr[0], a);
            if (j == 3) chk("load d_rdata", d_rdata[0], expv);
            step();
        end
        d_req[0] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  gv;
        logic [31:0] first_addr, got_data;
        int n, nr, nen, nir_before;
        bit ir, dr, seen, got_en, done;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 0; i_addr[k] = 0; d_req[k] = 0; d_we[k] = 0;
            d_addr[k] = 0; d_wdata[k] = 0; d_be[k] = 0; flush[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("reset mem_en", mem_en[0], 0);
        chk("reset i_ready", i_ready[0], 0);
        chk("reset d_ready", d_ready[0], 0);
        chk("reset i_rdata", i_rdata[0], 0);
        chk("reset d_rdata", d_rdata[0], 0);
        chk("reset d_rdata b", d_rdata[1], 0);
        step();

        load_literal(32'h100, 32'hDEADBEEF);
        step();

        // Both requesters held continuously: fetch must win every third grant.
        i_req[0] = 1; i_addr[0] = 32'h1000; d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h2000;
        n = 0; gv = '0;
        for (int c = 0; c < 100 && n < 6; c++) begin
            @(negedge clk);
            if (mem_en[0]) begin gv = {gv[4:0], (mem_addr[0] < 32'h2000)}; n++; end
            ir = i_ready[0]; dr = d_ready[0];
            step();
            if (ir) i_addr[0] += 4;
            if (dr) d_addr[0] += 4;
        end
        chk("starve grant count", n, 6);
        chk("starve grant order DDIDDI", {26'b0, gv}, 32'b001001);
        for (int c = 0; c < 50 && (i_req[0] || d_req[0]); c++) begin
            @(negedge clk);
            ir = i_ready[0]; dr = d_ready[0];
            step();
            if (ir) i_req[0] = 0;
            if (dr) d_req[0] = 0;
        end
        chk("starve drain", {30'b0, i_req[0], d_req[0]}, 0);

        // Flush during WAIT of the 0x40 fetch, redirect to 0x80.
        i_req[0] = 1; i_addr[0] = 32'h40; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_en[0] && mem_addr[0] == 32'h40) seen = 1;
            step();
        end
        chk("flush 0x40 issued", seen, 1);
        flush[0] = 1; i_addr[0] = 32'h80;
        step();
        flush[0] = 0;
        nir_before = 0; first_addr = 0; got_data = 0; got_en = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (i_ready[0]) begin
                if (!got_en) nir_before++;
                else begin got_data = i_rdata[0]; done = 1; end
            end
            if (mem_en[0] && !got_en) begin got_en = 1; first_addr = mem_addr[0]; end
            step();
        end
        i_req[0] = 0;
        chk("flush stale i_ready", nir_before, 0);
        chk("flush next mem_addr", first_addr, 32'h80);
        chk("flush i_ready seen", done, 1);
        chk("flush i_rdata", got_data, 32'h808093D7);

        // Store on the LATENCY=3 instance.
        d_req[1] = 1; d_we[1] = 1; d_addr[1] = 32'h200; d_wdata[1] = 32'h1234; d_be[1] = 4'b0011;
        nen = 0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (mem_en[1]) begin
                nen++;
                chk("store mem_we", mem_we[1], 1);
                chk("store mem_be", mem_be[1], 4'b0011);
                chk("store mem_addr", mem_addr[1], 32'h200);
                chk("store mem_wdata", mem_wdata[1], 32'h1234);
            end
            chk($sformatf("store d_ready t+%0d", j), d_ready[1], j == 5);
            step();
            if (j == 5) begin d_req[1] = 0; d_we[1] = 0; end
        end
        chk("store mem_en cycles", nen, 1);

        // Reset during WAIT of a load abandons it.
        d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h300;
        @(negedge clk); step();
        @(negedge clk);
        chk("rstwait mem_en", mem_en[0], 1);
        step();
        rst = 1; d_req[0] = 0;
        step();
        rst = 0;
        @(negedge clk);
        chk("rstwait post mem_en", mem_en[0], 0);
        chk("rstwait post d_ready", d_ready[0], 0);
        chk("rstwait post i_ready", i_ready[0], 0);
        chk("rstwait post d_rdata", d_rdata[0], 0);
        chk("rstwait post i_rdata", i_rdata[0], 0);
        step();
        nr = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            nr += int'(d_ready[0]) + int'(i_ready[0]);
            step();
        end
        chk("rstwait no ready", nr, 0);
        load_literal(32'h100, 32'hDEADBEEF);
        step();

        // flush_i with i_req in the same IDLE cycle: grant deferred one cycle.
        i_req[0] = 1; i_addr[0] = 32'h500; flush[0] = 1;
        @(negedge clk);
        step();
        flush[0] = 0;
        @(negedge clk);
        chk("flushidle no grant", mem_en[0], 0);
        step();
        @(negedge clk);
        chk("flushidle grant next", mem_en[0], 1);
        chk("flushidle mem_addr", mem_addr[0], 32'h500);
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            step();
            @(negedge clk);
            if (i_ready[0]) done = 1;
        end
        chk("flushidle i_ready", done, 1);
        step();
        i_req[0] = 0;

        // flush_i in the RESP cycle of a fetch on the LATENCY=3 instance.
        i_req[1] = 1; i_addr[1] = 32'h600; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_en[1]) seen = 1;
            step();
        end
        chk("respflush issued", seen, 1);
        repeat (3) step();
        flush[1] = 1; i_req[1] = 0;
        @(negedge clk);
        chk("respflush i_ready", i_ready[1], 0);
        step();
        flush[1] = 0;

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between two requesters: the fetch stage (I) and the memory stage's load/store (D).
- Runs a one-outstanding-access sequencer and returns stall requests to the hazard/pipeline control so that a stage holds until its access completes.
- Drops a fetch that a taken branch has made stale.
- Sits between the pipeline stage registers and the memory macro.

Parameters:
- LATENCY, 1: cycles from the mem_en cycle to the cycle in which mem_rdata is valid; must be ≥1.
- STARVE_MAX, 4: consecutive arbitrations fetch may lose before it is forced to win; must be ≥1.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- i_req  in  1  fetch access request; held until i_ready or flush
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetch data; valid when i_ready=1
- i_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data access request; held until d_ready
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_be  in  DW/8  store byte enables
- d_rdata  out  DW  load data; valid when d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- flush_i  in  1  branch redirect (PCSrcE); kills any fetch not yet completed
- mem_en  out  1  memory command strobe, one cycle per access
- mem_we  out  1  write enable
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_be  out  DW/8  byte enables
- mem_rdata  in  DW  read data
- stall_f  out  1  i_req & ~i_ready (combinational)
- stall_m  out  1  d_req & ~d_ready (combinational)

Behaviour:
- State machine: IDLE → ISSUE → WAIT → RESP → IDLE. All transitions occur on rising clk.
- IDLE, arbitration:
  - A winner is selected if any request is eligible.
  - Default priority is D over I.
  - If starve_cnt == STARVE_MAX and i_req is eligible, I wins.
  - I is ineligible in any cycle with flush_i=1.
  - The winner's owner, addr, we, wdata and be are latched; go to ISSUE.
  - If no request is eligible, stay in IDLE.
  - A fetch access always has we=0 and be=all ones.
- starve_cnt rules:
  - Increments, saturating at STARVE_MAX, when D wins while i_req=1 and I is eligible.
  - Clears when I wins.
  - Otherwise holds.
- ISSUE: mem_en=1 for exactly this cycle, with the latched command on mem_*; go to WAIT with wait_cnt=LATENCY-1.
- WAIT:
  - If wait_cnt==0, register mem_rdata into the owner's rdata register and go to RESP.
  - Otherwise decrement wait_cnt.
  - With LATENCY=1, WAIT lasts one cycle.
- RESP:
  - Pulse the owner's ready for one cycle.
  - If the owner is I and the kill flag is set, i_ready stays 0 and no data is delivered.
  - Return to IDLE.
- Timing: a request seen in IDLE at cycle t gives mem_en at t+1, mem_rdata sampled at the end of cycle t+1+LATENCY, and ready at t+2+LATENCY. The next arbitration is at t+3+LATENCY.
- Writes follow the same timing; d_rdata is don't-care on a store.
- kill flag:
  - Set when flush_i=1 while the owner is I in ISSUE, WAIT or RESP.
  - Cleared on entry to ISSUE.
  - flush_i has no effect on a D access.
  - A started memory read is never aborted; it completes and its data is discarded.
- Holding outputs:
  - i_rdata and d_rdata hold their last captured value outside the ready cycle.
  - mem_addr, mem_we, mem_wdata and mem_be hold the latched command; they are only meaningful while mem_en=1.
- Requester rules:
  - A requester must not change addr or data while its req=1 and ready=0.
  - Deasserting req before ready is allowed only for I under flush.
- Reset: state=IDLE, mem_en=0, i_ready=0, d_ready=0, kill=0, starve_cnt=0, wait_cnt=0, rdata registers=0.
  - Reset mid-access abandons the access; a later mem_rdata is ignored.
- Simultaneous events:
  - d_req and i_req with starve_cnt<STARVE_MAX: D is granted.
  - flush_i and i_req in the same IDLE cycle with no d_req: stay in IDLE.
  - flush_i in the RESP cycle of an I access suppresses that i_ready.

Test Plan:
- LATENCY=1, single load d_addr=0x100, mem returns 0xDEADBEEF → mem_en at t+1, d_ready=1 with d_rdata=0xDEADBEEF at t+3, stall_m=1 during t..t+2.
- i_req and d_req both held continuously, STARVE_MAX=2 → grant order D, D, I, D, D, I; fetch is never idle for more than 2 accesses.
- Fetch in flight at 0x40, flush_i pulsed during WAIT, new i_addr=0x80 → no i_ready for 0x40; next access shows mem_addr=0x80 and i_ready returns the 0x80 data.
- Store d_we=1, d_be=4'b0011, d_wdata=0x1234 at 0x200, LATENCY=3 → one mem_en cycle with mem_we=1, mem_be=0011; d_ready at t+5.
- rst asserted during WAIT of a load → next cycle all outputs at reset values; no ready pulse afterwards; a fresh request starts at IDLE timing.
- flush_i and i_req in the same IDLE cycle, no d_req → no grant that cycle; grant the following cycle once flush_i=0.
